key_motion_arbiter: RTL and testbench

KEY_MOTION_ARBITER -- requirements
Module: key_motion_arbiter

---
 rtl/key_motion_arbiter.sv | 148 ++++++++++++++
 tb/tb_key_motion_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/key_motion_arbiter.sv
// Picks one direction keycode from four HID key slots for the ball motion block, with a frame holdoff after each new selection.
// Optional macro KEY_LATCH_EN: keep the last keycode on ACTIVE->IDLE instead of clearing it to 8'h00.
module key_motion_arbiter #(
    parameter int          HOLDOFF_FRAMES = 4,
    parameter logic [7:0]  KEY_UP         = 8'h1A,
    parameter logic [7:0]  KEY_DOWN       = 8'h16,
    parameter logic [7:0]  KEY_LEFT       = 8'h04,
    parameter logic [7:0]  KEY_RIGHT      = 8'h07
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic [31:0] keycodes,
    output logic [7:0]  keycode_out,
    output logic        key_valid,
    output logic        dir_change,
    output logic [1:0]  dbg_state
);

    localparam int CW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (HOLDOFF_FRAMES > 0) ? CW'(HOLDOFF_FRAMES - 1) : '0;

    typedef enum logic [1:0] {IDLE = 2'd0, HOLDOFF = 2'd1, ACTIVE = 2'd2} state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [31:0]   r_prev;
    logic [7:0]    r_key, w_key_n;
    logic          r_valid, w_valid_n;
    logic          r_dc, w_dc_n;

    logic [3:0]    w_dir, w_new, w_new_other;
    logic          w_cur_present;
    logic          w_sel;
    logic [7:0]    w_sel_key;

    function automatic logic [7:0] slot_of(input logic [31:0] v, input int i);
        return v[i*8 +: 8];
    endfunction

    function automatic logic is_dir(input logic [7:0] k);
        return (k == KEY_UP) || (k == KEY_DOWN) || (k == KEY_LEFT) || (k == KEY_RIGHT);
    endfunction

    function automatic logic in_word(input logic [7:0] k, input logic [31:0] v);
        return (k == v[7:0]) || (k == v[15:8]) || (k == v[23:16]) || (k == v[31:24]);
    endfunction

    // Walking downward leaves the lowest-index marked slot as the result.
    function automatic logic [7:0] pick_lowest(input logic [3:0] m, input logic [31:0] v);
        logic [7:0] res;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) res = slot_of(v, i);
        end
        return res;
    endfunction

    always_comb begin : decode
        w_dir         = '0;
        w_new         = '0;
        w_new_other   = '0;
        w_cur_present = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_dir[i]       = is_dir(slot_of(keycodes, i));
            w_new[i]       = w_dir[i] && !in_word(slot_of(keycodes, i), r_prev);
            w_new_other[i] = w_new[i] && (slot_of(keycodes, i) != r_key);
            if (w_dir[i] && (slot_of(keycodes, i) == r_key)) w_cur_present = 1'b1;
        end
    end

    always_comb begin : next_state
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_key_n   = r_key;
        w_valid_n = r_valid;
        w_sel     = 1'b0;
        w_sel_key = '0;
        case (r_state)
            IDLE: begin
                if (|w_dir) begin
                    w_sel     = 1'b1;
                    w_sel_key = (|w_new) ? pick_lowest(w_new, keycodes) : pick_lowest(w_dir, keycodes);
                end
            end
            HOLDOFF: begin
                if (r_cnt == '0) w_state_n = ACTIVE;
                else             w_cnt_n   = r_cnt - CW'(1);
            end
            ACTIVE: begin
                if (|w_new_other) begin
                    w_sel     = 1'b1;
                    w_sel_key = pick_lowest(w_new_other, keycodes);
                end else if (!w_cur_present) begin
                    if (|w_dir) begin
                        w_sel     = 1'b1;
                        w_sel_key = (|w_new) ? pick_lowest(w_new, keycodes) : pick_lowest(w_dir, keycodes);
                    end else begin
                        w_state_n = IDLE;
                        w_valid_n = 1'b0;
`ifdef KEY_LATCH_EN
                        w_key_n   = r_key;
`else
                        w_key_n   = '0;
`endif
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        if (w_sel) begin
            w_key_n   = w_sel_key;
            w_valid_n = 1'b1;
            if (HOLDOFF_FRAMES == 0) begin
                w_state_n = ACTIVE;
                w_cnt_n   = '0;
            end else begin
                w_state_n = HOLDOFF;
                w_cnt_n   = CNT_LOAD;
            end
        end
        // The pulse tracks the value itself, so a reselection of the same key stays silent.
        w_dc_n = (w_key_n != r_key);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prev  <= '0;
            r_key   <= '0;
            r_valid <= 1'b0;
            r_dc    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_prev  <= keycodes;
            r_key   <= w_key_n;
            r_valid <= w_valid_n;
            r_dc    <= w_dc_n;
        end
    end

    assign keycode_out = r_key;
    assign key_valid   = r_valid;
    assign dir_change  = r_dc;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_key_motion_arbiter.sv
// Scoreboard bench for key_motion_arbiter (HOLDOFF_FRAMES=4); expectations follow KEY_LATCH_EN when defined.
module tb_key_motion_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;

    logic        frame_clk;
    logic        Reset_n;
    logic [31:0] keycodes;
    logic [7:0]  keycode_out;
    logic        key_valid;
    logic        dir_change;
    logic [1:0]  dbg_state;

    // expected word: {state, keycode_out, key_valid, dir_change}
    logic [11:0] exp_q[$];
    int          checks;
    int          failures;

    key_motion_arbiter #(.HOLDOFF_FRAMES(4)) dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .keycodes    (keycodes),
        .keycode_out (keycode_out),
        .key_valid   (key_valid),
        .dir_change  (dir_change),
        .dbg_state   (dbg_state)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got st=%0d key=%02h v=%0b dc=%0b, want st=%0d key=%02h v=%0b dc=%0b",
                     tag, obs[11:10], obs[9:2], obs[1], obs[0],
                     exp_v[11:10], exp_v[9:2], exp_v[1], exp_v[0]);
        end
    endtask

    function automatic logic [11:0] observed();
        return {dbg_state, keycode_out, key_valid, dir_change};
    endfunction

    // Drive one frame of keycodes, queue what must appear after the edge, then compare.
    task automatic step(input string tag, input logic [31:0] kc, input logic [1:0] st,
                        input logic [7:0] key, input logic v, input logic dc);
        keycodes = kc;
        exp_q.push_back({st, key, v, dc});
        @(posedge frame_clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check(tag, observed(), exp_q.pop_front());
        end
    endtask

    logic [7:0] idle_key;
    logic       idle_dc;

    initial begin
        checks   = 0;
        failures = 0;
        keycodes = '0;
        Reset_n  = 1'b0;
        #12;
        check("reset", observed(), {S_IDLE, 8'h00, 1'b0, 1'b0});
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;

        // Non-direction keys are ignored entirely.
        for (int i = 0; i < 3; i++) step("nondir", 32'hFF00_002C, S_IDLE, 8'h00, 1'b0, 1'b0);

        // Right at frame 0, Left joins at frame 2, Right released at frame 6.
        step("sel_07",  32'h0000_0007, S_HOLD, 8'h07, 1'b1, 1'b1);
        step("hold_f1", 32'h0000_0007, S_HOLD, 8'h07, 1'b1, 1'b0);
        step("hold_f2", 32'h0000_0407, S_HOLD, 8'h07, 1'b1, 1'b0);
        step("hold_f3", 32'h0000_0407, S_HOLD, 8'h07, 1'b1, 1'b0);
        step("act_f4",  32'h0000_0407, S_ACT,  8'h07, 1'b1, 1'b0);
        step("act_f5",  32'h0000_0407, S_ACT,  8'h07, 1'b1, 1'b0);
        step("sel_04",  32'h0000_0400, S_HOLD, 8'h04, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("hold_04", 32'h0000_0400, S_HOLD, 8'h04, 1'b1, 1'b0);
        step("act_04",  32'h0000_0400, S_ACT,  8'h04, 1'b1, 1'b0);

`ifdef KEY_LATCH_EN
        idle_key = 8'h04;
        idle_dc  = 1'b0;
`else
        idle_key = 8'h00;
        idle_dc  = 1'b1;
`endif
        step("rel_04",  32'h0000_0000, S_IDLE, idle_key, 1'b0, idle_dc);
        step("idle_04", 32'h0000_0000, S_IDLE, idle_key, 1'b0, 1'b0);

        // Two simultaneous new presses: lowest slot wins.
        step("sel_16",  32'h001A_1600, S_HOLD, 8'h16, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("hold_16", 32'h001A_1600, S_HOLD, 8'h16, 1'b1, 1'b0);
        step("act_16",  32'h001A_1600, S_ACT,  8'h16, 1'b1, 1'b0);

        // New different press in ACTIVE, then releases during holdoff are ignored.
        step("sel_07b", 32'h071A_1600, S_HOLD, 8'h07, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("hold_rel", 32'h0000_0000, S_HOLD, 8'h07, 1'b1, 1'b0);
        step("act_rel", 32'h0000_0000, S_ACT,  8'h07, 1'b1, 1'b0);

`ifdef KEY_LATCH_EN
        idle_key = 8'h07;
        idle_dc  = 1'b0;
`else
        idle_key = 8'h00;
        idle_dc  = 1'b1;
`endif
        step("rel_07",  32'h0000_0000, S_IDLE, idle_key, 1'b0, idle_dc);

        // Up held, then moved from slot0 to slot2 in one frame: no reselection.
        step("sel_1a",  32'h0000_001A, S_HOLD, 8'h1A, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("hold_1a", 32'h0000_001A, S_HOLD, 8'h1A, 1'b1, 1'b0);
        step("act_1a",  32'h0000_001A, S_ACT,  8'h1A, 1'b1, 1'b0);
        step("act_1a2", 32'h0000_001A, S_ACT,  8'h1A, 1'b1, 1'b0);
        step("move_1a", 32'h001A_0000, S_ACT,  8'h1A, 1'b1, 1'b0);
        step("keep_1a", 32'h001A_0000, S_ACT,  8'h1A, 1'b1, 1'b0);

        // Selected key gone, another held: reselect.
        step("swap_07", 32'h0000_0007, S_HOLD, 8'h07, 1'b1, 1'b1);
        step("hold_sw", 32'h0000_0007, S_HOLD, 8'h07, 1'b1, 1'b0);

        // Asynchronous reset mid-holdoff, key still held.
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst", observed(), {S_IDLE, 8'h00, 1'b0, 1'b0});
        @(posedge frame_clk);
        #1;
        check("rst_hold", observed(), {S_IDLE, 8'h00, 1'b0, 1'b0});
        Reset_n = 1'b1;
        step("post_rst",  32'h0000_0007, S_HOLD, 8'h07, 1'b1, 1'b1);
        step("post_rst2", 32'h0000_0007, S_HOLD, 8'h07, 1'b1, 1'b0);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover: %0d expected entries unconsumed, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
